// File: rtl/tetris_pkg.sv
// Shared Tetris core definitions: default geometry,
// coordinate widths, kick offsets and rotate_kick states.
package tetris_pkg;

  localparam int N_DEF       = 4;
  localparam int BOARD_W_DEF = 10;
  localparam int BOARD_H_DEF = 20;

  function automatic int xw_of(input int w);
    return $clog2(w) + 2;
  endfunction

  function automatic int yw_of(input int h);
    return $clog2(h) + 2;
  endfunction

  // Offsets 0, -1, +1, -2, +2, ...
  function automatic int kick_dx(input int k);
    return k[0] ? -((k + 1) / 2) : k / 2;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROT,
    S_CHECK,
    S_DONE
  } rk_state_t;

endpackage

// File: rtl/rotate_mask.sv
// Combinational NxN piece-mask rotation,
// clockwise when i_dir=0, counter-clockwise when 1.
module rotate_mask #(
  parameter int N = 4
) (
  input  logic [N*N-1:0] i_mask,
  input  logic           i_dir,
  output logic [N*N-1:0] o_mask
);

  always_comb begin
    o_mask = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        o_mask[i*N+j] = i_dir ?
          i_mask[j*N+(N-1-i)] :
          i_mask[(N-1-j)*N+i];
      end
    end
  end

endmodule

// File: rtl/rotate_kick.sv
// Rotates the falling piece and searches horizontal kicks
// against the settled board, one board row per cycle.
module rotate_kick
  import tetris_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int BOARD_W = BOARD_W_DEF,
  parameter int BOARD_H = BOARD_H_DEF,
  parameter int KICKS   = 3,
  parameter int XW      = xw_of(BOARD_W),
  parameter int YW      = yw_of(BOARD_H)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [N*N-1:0]       req_float,
  input  logic                 req_dir,
  input  logic [XW-1:0]        req_x,
  input  logic [YW-1:0]        req_y,
  output logic                 row_rd,
  output logic [YW-2:0]        row_addr,
  input  logic [BOARD_W-1:0]   row_data,
  output logic                 resp_valid,
  output logic                 resp_ok,
  output logic [N*N-1:0]       resp_float,
  output logic [XW-1:0]        resp_x
);

  localparam int CW  = $clog2(N + 1);
  localparam int KW  = $clog2(KICKS) + 1;
  localparam int CXW = $clog2(BOARD_W);

  localparam logic signed [YW-1:0] Y_ONE = 1;
  localparam logic signed [YW-1:0] Y_H   = BOARD_H;
  localparam logic signed [XW-1:0] X_W   = BOARD_W;

  rk_state_t             r_state;
  logic [N*N-1:0]        r_float;
  logic [N*N-1:0]        r_rot;
  logic                  r_dir;
  logic signed [XW-1:0]  r_x;
  logic signed [YW-1:0]  r_y;
  logic [KW-1:0]         r_k;
  logic [CW-1:0]         r_c;
  logic                  r_coll;

  logic [N*N-1:0]        w_rot;
  logic signed [XW-1:0]  w_dx;
  logic signed [YW-1:0]  w_c_s;
  logic signed [YW-1:0]  w_ry;
  logic signed [XW-1:0]  w_cx;
  int                    w_row;
  logic                  w_hit;
  logic                  w_coll_all;
  logic                  w_last_c;
  logic                  w_last_k;
  logic                  w_iss_en;
  logic signed [YW-1:0]  w_iss_row;
  logic                  w_rd_ok;

  rotate_mask #(.N(N)) u_rot (
    .i_mask (r_float),
    .i_dir  (r_dir),
    .o_mask (w_rot)
  );

  assign req_ready  = (r_state == S_IDLE);
  assign w_dx       = XW'(kick_dx(int'(r_k)));
  assign w_c_s      = YW'(r_c);
  assign w_ry       = r_y + w_c_s - Y_ONE;
  assign w_row      = int'(r_c) - 1;
  assign w_coll_all = r_coll | w_hit;
  assign w_last_c   = (r_c == CW'(N));
  assign w_last_k   = (r_k == KW'(KICKS - 1));

  // Evaluate mask row c-1 against the row fetched last cycle
  always_comb begin
    w_hit = 1'b0;
    w_cx  = '0;
    if (r_state == S_CHECK && r_c != '0) begin
      for (int j = 0; j < N; j++) begin
        w_cx = r_x + w_dx + XW'(j);
        if (r_rot[w_row*N+j]) begin
          if (w_cx < 0 || w_cx >= X_W || w_ry >= Y_H)
            w_hit = 1'b1;
          else if (w_ry >= 0 && row_data[w_cx[CXW-1:0]])
            w_hit = 1'b1;
        end
      end
    end
  end

  // Row to present on the read port during the next cycle
  always_comb begin
    w_iss_en  = 1'b0;
    w_iss_row = r_y;
    unique case (1'b1)
      (r_state == S_ROT): w_iss_en = 1'b1;
      (r_state == S_CHECK): begin
        if (r_c < CW'(N - 1)) begin
          w_iss_en  = 1'b1;
          w_iss_row = r_y + w_c_s + Y_ONE;
        end else if (w_last_c && w_coll_all && !w_last_k) begin
          w_iss_en = 1'b1;
        end
      end
      default: w_iss_en = 1'b0;
    endcase
  end

  assign w_rd_ok = w_iss_en && !w_iss_row[YW-1] &&
                   (w_iss_row < Y_H);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_float    <= '0;
      r_rot      <= '0;
      r_dir      <= 1'b0;
      r_x        <= '0;
      r_y        <= '0;
      r_k        <= '0;
      r_c        <= '0;
      r_coll     <= 1'b0;
      row_rd     <= 1'b0;
      row_addr   <= '0;
      resp_valid <= 1'b0;
      resp_ok    <= 1'b0;
      resp_float <= '0;
      resp_x     <= '0;
    end else begin
      resp_valid <= 1'b0;
      row_rd     <= w_rd_ok;
      if (w_rd_ok)
        row_addr <= w_iss_row[YW-2:0];
      unique case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_float <= req_float;
            r_dir   <= req_dir;
            r_x     <= req_x;
            r_y     <= req_y;
            r_state <= S_ROT;
          end
        end
        S_ROT: begin
          r_rot   <= w_rot;
          r_k     <= '0;
          r_c     <= '0;
          r_coll  <= 1'b0;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (!w_last_c) begin
            r_c    <= r_c + 1'b1;
            r_coll <= w_coll_all;
          end else if (!w_coll_all) begin
            resp_valid <= 1'b1;
            resp_ok    <= 1'b1;
            resp_float <= r_rot;
            resp_x     <= r_x + w_dx;
            r_state    <= S_DONE;
          end else if (!w_last_k) begin
            r_k    <= r_k + 1'b1;
            r_c    <= '0;
            r_coll <= 1'b0;
          end else begin
            resp_valid <= 1'b1;
            resp_ok    <= 1'b0;
            resp_float <= r_float;
            resp_x     <= r_x;
            r_state    <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rotate_kick.sv
// Scoreboard bench for rotate_kick: a board-RAM responder,
// a reference kick search and latency/ready checks.
module tb_rotate_kick;

  localparam int N  = 4;
  localparam int BW = 10;
  localparam int BH = 20;
  localparam int KK = 3;
  localparam int XW = 6;
  localparam int YW = 7;

  typedef struct {
    logic        ok;
    logic [15:0] fl;
    int          x;
    int          cyc;
  } exp_t;

  logic          clk = 0;
  logic          rst = 1;
  logic          req_valid = 0;
  logic          req_ready;
  logic [15:0]   req_float = '0;
  logic          req_dir = 0;
  logic [XW-1:0] req_x = '0;
  logic [YW-1:0] req_y = '0;
  logic          row_rd;
  logic [YW-2:0] row_addr;
  logic [BW-1:0] row_data = '0;
  logic          resp_valid;
  logic          resp_ok;
  logic [15:0]   resp_float;
  logic [XW-1:0] resp_x;

  logic [BW-1:0] board [BH];
  exp_t          sbq [$];
  int            rd_log [$];
  exp_t          e;
  logic [XW-1:0] ex;
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;
  bit            busy = 0;

  rotate_kick #(
    .N(N), .BOARD_W(BW), .BOARD_H(BH), .KICKS(KK),
    .XW(XW), .YW(YW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_float  (req_float),
    .req_dir    (req_dir),
    .req_x      (req_x),
    .req_y      (req_y),
    .row_rd     (row_rd),
    .row_addr   (row_addr),
    .row_data   (row_data),
    .resp_valid (resp_valid),
    .resp_ok    (resp_ok),
    .resp_float (resp_float),
    .resp_x     (resp_x)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Board RAM: data the cycle after a read, junk otherwise
  always @(posedge clk) begin
    if (row_rd && int'(row_addr) < BH)
      row_data <= board[row_addr];
    else
      row_data <= BW'($urandom);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(
    input  logic [15:0] f, input bit d,
    input  int x, input int y,
    output logic ok, output logic [15:0] fo,
    output int xo, output int lat);
    logic [15:0] r;
    bit coll;
    int dx, cx, ry;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        r[i*N+j] = d ? f[j*N+(N-1-i)] : f[(N-1-j)*N+i];
    ok = 0; fo = f; xo = x;
    lat = 3 + N + (KK - 1) * (N + 1);
    for (int k = 0; k < KK; k++) begin
      dx = (k % 2) ? -((k + 1) / 2) : k / 2;
      coll = 0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (r[i*N+j]) begin
            cx = x + dx + j;
            ry = y + i;
            if (cx < 0 || cx >= BW || ry >= BH) coll = 1;
            else if (ry >= 0 && board[ry][cx]) coll = 1;
          end
      if (!coll) begin
        ok = 1; fo = r; xo = x + dx;
        lat = 3 + N + k * (N + 1);
        return;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (row_rd) rd_log.push_back(int'(row_addr));
    if (busy && !resp_valid)
      check("ready_busy", {31'b0, req_ready}, 0);
    if (resp_valid) begin
      if (sbq.size() == 0) begin
        check("spurious_resp", {31'b0, resp_valid}, 0);
      end else begin
        e  = sbq.pop_front();
        ex = e.x[XW-1:0];
        check("resp_ok", {31'b0, resp_ok}, {31'b0, e.ok});
        check("resp_float", {16'b0, resp_float}, {16'b0, e.fl});
        check("resp_x", {26'b0, resp_x}, {26'b0, ex});
        check("resp_cycle", cyc, e.cyc);
      end
      busy = 0;
    end
  end

  // Call at a negedge; returns just after the accepting edge
  task automatic send(input logic [15:0] f, input bit d,
                      input int x, input int y,
                      input bit keep, output int acc);
    int n, xo, lat;
    logic ok;
    logic [15:0] fo;
    exp_t t;
    req_float = f; req_dir = d;
    req_x = x[XW-1:0]; req_y = y[YW-1:0];
    req_valid = 1;
    n = 0;
    while (!req_ready && n < 64) begin
      @(negedge clk); n++;
    end
    check("accept", {31'b0, req_ready}, 1);
    acc = cyc;
    model(f, d, x, y, ok, fo, xo, lat);
    t.ok = ok; t.fl = fo; t.x = xo; t.cyc = cyc + lat;
    sbq.push_back(t);
    @(posedge clk);
    busy = 1;
    #1;
    if (!keep) req_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    check("drain", sbq.size(), 0);
    sbq.delete();
    @(negedge clk);
  endtask

  task automatic clear_board();
    for (int r = 0; r < BH; r++) board[r] = '0;
  endtask

  int a1, a2;
  logic [15:0] rf;

  initial begin
    clear_board();
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 1);
    check("rst_valid", {31'b0, resp_valid}, 0);
    check("rst_ok", {31'b0, resp_ok}, 0);
    check("rst_float", {16'b0, resp_float}, 0);
    check("rst_x", {26'b0, resp_x}, 0);
    check("rst_rd", {31'b0, row_rd}, 0);
    check("rst_addr", {25'b0, row_addr}, 0);
    rst = 0;
    @(negedge clk);
    check("ready_after_rst", {31'b0, req_ready}, 1);

    // Horizontal I on empty board, kick 0
    send(16'h00F0, 0, 3, 0, 0, a1);
    drain();
    // Vertical I at left wall, fits at +1
    send(16'h2222, 0, -1, 5, 0, a1);
    drain();
    // Rows 5..8 full: every kick collides
    for (int r = 5; r <= 8; r++) board[r] = '1;
    send(16'h2222, 0, 3, 5, 0, a1);
    drain();
    clear_board();
    // Above the board, counter-clockwise
    rd_log.delete();
    send(16'h00F0, 1, 3, -2, 0, a1);
    drain();
    check("neg_y_reads", rd_log.size(), 2);
    if (rd_log.size() == 2) begin
      check("neg_y_row0", rd_log[0], 0);
      check("neg_y_row1", rd_log[1], 1);
    end

    // Reset in the middle of a search
    @(negedge clk);
    send(16'h00F0, 0, 3, 0, 0, a1);
    while (cyc != a1 + 4) @(negedge clk);
    rst = 1;
    sbq.delete();
    busy = 0;
    @(negedge clk);
    rst = 0;
    check("abort_ready", {31'b0, req_ready}, 1);
    check("abort_valid", {31'b0, resp_valid}, 0);
    check("abort_ok", {31'b0, resp_ok}, 0);
    send(16'h00F0, 0, 3, 0, 0, a2);
    check("abort_restart", a2 - a1, 5);
    drain();

    // Back-to-back with req_valid held high
    send(16'h00F0, 0, 3, 0, 1, a1);
    @(negedge clk);
    send(16'h0660, 1, 2, 4, 0, a2);
    check("b2b_gap", a2 - a1, 8);
    drain();

    // All-zero mask
    send(16'h0000, 1, -3, 25, 0, a1);
    drain();

    // Random boards and pieces
    for (int t = 0; t < 12; t++) begin
      clear_board();
      for (int r = 8; r < BH; r++)
        board[r] = BW'($urandom & $urandom);
      rf = 16'($urandom & $urandom);
      send(rf, 1'($urandom), $urandom_range(0, 10) - 2,
           $urandom_range(0, 20) - 3, 0, a1);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1);
  end

endmodule
